// File: rtl/program_counter_stack.sv
// program_counter_stack
//   Instruction-address generator for the associative processor control path.
//   It advances the fetch address under the instruction-cache handshake and
//   handles call / return / jump. A hardware return-address stack holds call
//   and interrupt frames. A rising edge on int_req is latched as a pending
//   interrupt, which redirects fetch to INT_VECTOR.
//
//   Optional feature macro: PC_INT_NEST_EN
//     defined   - a pending interrupt may enter while already in an ISR (nesting)
//     undefined - a pending interrupt waits until no interrupt frame is stacked
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous reset, active low
//   int_req          in   interrupt request level (rising edge captured)
//   ret_valid        in   return: pop stack into addr_ins
//   call_valid       in   call: push addr_ins+1, load call_addr
//   call_addr        in   call target
//   jmp_valid        in   jump: load jmp_addr
//   jmp_addr         in   jump target
//   ins_inp_valid    in   AP_ctrl accepts current instruction
//   ins_cache_rdy    in   instruction cache ready
//   st_cur_ins_cache in   cache state (SENT_INS = 3)
//   load_times       in   number of completed cache loads
//   addr_ins         out  fetch address to the cache
//   addr_cur_ins     out  current instruction address to AP_ctrl
//   in_isr           out  an interrupt frame is on the stack
//   stack_depth      out  occupied stack entries
//   stack_ovf        out  sticky push-while-full flag
//   stack_unf        out  sticky pop-while-empty flag
module program_counter_stack #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int RET_DEPTH       = 8,
  parameter logic [ADDR_WIDTH_MEM-1:0] INT_VECTOR = ADDR_WIDTH_MEM'(1) << (ADDR_WIDTH_MEM-1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          int_req,
  input  logic                          ret_valid,
  input  logic                          call_valid,
  input  logic [ADDR_WIDTH_MEM-1:0]     call_addr,
  input  logic                          jmp_valid,
  input  logic [ADDR_WIDTH_MEM-1:0]     jmp_addr,
  input  logic                          ins_inp_valid,
  input  logic                          ins_cache_rdy,
  input  logic [3:0]                    st_cur_ins_cache,
  input  logic [9:0]                    load_times,
  output logic [ADDR_WIDTH_MEM-1:0]     addr_ins,
  output logic [ADDR_WIDTH_MEM-1:0]     addr_cur_ins,
  output logic                          in_isr,
  output logic [$clog2(RET_DEPTH):0]    stack_depth,
  output logic                          stack_ovf,
  output logic                          stack_unf
);

  localparam int SW = $clog2(RET_DEPTH);
  localparam int DW = SW + 1;
  localparam int PW = ADDR_WIDTH_MEM + 10;
  localparam logic [3:0]    SENT_INS   = 4'd3;
  localparam logic [PW-1:0] ISA_DEPTH_W = PW'(ISA_DEPTH);
  localparam logic [PW-1:0] TOTAL_W     = PW'(TOTAL_ISA_DEPTH);
  localparam logic [DW-1:0] FULL_W      = DW'(RET_DEPTH);

  // Return-stack storage: address part and is_int part of each {is_int, addr}
  // entry. Flags of unoccupied entries are kept at 0 so in_isr is a plain OR.
  logic [ADDR_WIDTH_MEM-1:0] stk_addr [RET_DEPTH];
  logic [RET_DEPTH-1:0]      frame_int;

  logic int_q, int_pend;

  logic                      int_edge, int_allow, adv;
  logic [PW-1:0]             page_end;
  logic                      full, empty;
  logic [DW-1:0]             depth_m1;
  logic [SW-1:0]             top, wr_idx;

  logic                      push_req, pop_req, push_is_int, push_wr;
  logic [ADDR_WIDTH_MEM-1:0] push_addr;
  logic [ADDR_WIDTH_MEM-1:0] addr_ins_nx, addr_cur_nx;
  logic [DW-1:0]             depth_nx;
  logic [RET_DEPTH-1:0]      frame_int_nx;
  logic                      ovf_nx, unf_nx, pend_nx, in_isr_nx;

  assign int_edge = int_req & ~int_q;

`ifdef PC_INT_NEST_EN
  assign int_allow = 1'b1;
`else
  assign int_allow = ~in_isr;
`endif

  // Page boundary is computed wide enough that load_times never wraps it.
  assign page_end = ISA_DEPTH_W * {{ADDR_WIDTH_MEM{1'b0}}, load_times};
  assign adv = ins_inp_valid & ins_cache_rdy
             & (st_cur_ins_cache == SENT_INS)
             & ({10'd0, addr_ins} < TOTAL_W)
             & ({10'd0, addr_ins} != page_end);

  assign full     = (stack_depth == FULL_W);
  assign empty    = (stack_depth == '0);
  assign depth_m1 = stack_depth - DW'(1);
  assign top      = depth_m1[SW-1:0];
  assign wr_idx   = stack_depth[SW-1:0];
  assign push_wr  = push_req & ~full;

  always_comb begin
    addr_ins_nx  = addr_ins;
    addr_cur_nx  = addr_cur_ins;
    depth_nx     = stack_depth;
    frame_int_nx = frame_int;
    ovf_nx       = stack_ovf;
    unf_nx       = stack_unf;
    pend_nx      = int_pend | int_edge;   // new edges merge into a pending one
    push_req     = 1'b0;
    pop_req      = 1'b0;
    push_is_int  = 1'b0;
    push_addr    = '0;

    if (int_pend && int_allow) begin
      push_req    = 1'b1;
      push_is_int = 1'b1;
      push_addr   = addr_ins;
      addr_ins_nx = INT_VECTOR;
      pend_nx     = 1'b0;
    end else if (ret_valid) begin
      pop_req = 1'b1;
    end else if (call_valid) begin
      push_req    = 1'b1;
      push_addr   = addr_ins + ADDR_WIDTH_MEM'(1);
      addr_ins_nx = call_addr;
      addr_cur_nx = call_addr;
    end else if (jmp_valid) begin
      addr_ins_nx = jmp_addr;
      addr_cur_nx = jmp_addr;
    end else if (adv) begin
      addr_ins_nx = addr_ins + ADDR_WIDTH_MEM'(1);
      addr_cur_nx = addr_ins + ADDR_WIDTH_MEM'(1);
    end

    // A push into a full stack loses the frame but the redirect above stands.
    if (push_req) begin
      if (full) begin
        ovf_nx = 1'b1;
      end else begin
        depth_nx             = stack_depth + DW'(1);
        frame_int_nx[wr_idx] = push_is_int;
      end
    end

    // A pop from an empty stack leaves the fetch address where it is.
    if (pop_req) begin
      if (empty) begin
        unf_nx = 1'b1;
      end else begin
        addr_ins_nx       = stk_addr[top];
        addr_cur_nx       = stk_addr[top];
        frame_int_nx[top] = 1'b0;
        depth_nx          = depth_m1;
      end
    end

    in_isr_nx = |frame_int_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_ins     <= '0;
      addr_cur_ins <= '0;
      stack_depth  <= '0;
      frame_int    <= '0;
      in_isr       <= 1'b0;
      stack_ovf    <= 1'b0;
      stack_unf    <= 1'b0;
      int_pend     <= 1'b0;
      int_q        <= 1'b0;
    end else begin
      addr_ins     <= addr_ins_nx;
      addr_cur_ins <= addr_cur_nx;
      stack_depth  <= depth_nx;
      frame_int    <= frame_int_nx;
      in_isr       <= in_isr_nx;
      stack_ovf    <= ovf_nx;
      stack_unf    <= unf_nx;
      int_pend     <= pend_nx;
      int_q        <= int_req;
    end
  end

  // Stack addresses are pure data; occupancy is tracked by stack_depth.
  always_ff @(posedge clk) begin
    if (rst && push_wr) begin
      stk_addr[wr_idx] <= push_addr;
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed testbench for program_counter_stack (default parameters).
// Expectations for the nested-interrupt case follow PC_INT_NEST_EN.
module tb_program_counter_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, ret_valid, call_valid, jmp_valid;
  logic [15:0] call_addr, jmp_addr;
  logic        ins_inp_valid, ins_cache_rdy;
  logic [3:0]  st_cur_ins_cache;
  logic [9:0]  load_times;
  logic [15:0] addr_ins, addr_cur_ins;
  logic        in_isr;
  logic [3:0]  stack_depth;
  logic        stack_ovf, stack_unf;

  int n_chk  = 0;
  int n_fail = 0;

  program_counter_stack dut (
    .clk(clk), .rst(rst), .int_req(int_req), .ret_valid(ret_valid),
    .call_valid(call_valid), .call_addr(call_addr), .jmp_valid(jmp_valid),
    .jmp_addr(jmp_addr), .ins_inp_valid(ins_inp_valid), .ins_cache_rdy(ins_cache_rdy),
    .st_cur_ins_cache(st_cur_ins_cache), .load_times(load_times),
    .addr_ins(addr_ins), .addr_cur_ins(addr_cur_ins), .in_isr(in_isr),
    .stack_depth(stack_depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] a);
    jmp_valid = 1'b1;
    jmp_addr  = a;
    step();
    jmp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; int_req = 1'b0; ret_valid = 1'b0; call_valid = 1'b0;
    jmp_valid = 1'b0; call_addr = '0; jmp_addr = '0;
    ins_inp_valid = 1'b0; ins_cache_rdy = 1'b1; st_cur_ins_cache = 4'd3;
    load_times = 10'd1;

    // Reset state
    step(); step();
    check("rst_addr_ins", 32'(addr_ins), 0);
    check("rst_addr_cur", 32'(addr_cur_ins), 0);
    check("rst_depth", 32'(stack_depth), 0);
    check("rst_in_isr", 32'(in_isr), 0);
    check("rst_ovf", 32'(stack_ovf), 0);
    check("rst_unf", 32'(stack_unf), 0);
    rst = 1'b1;

    // Sequential advance
    ins_inp_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("adv5_addr_ins", 32'(addr_ins), 5);
    check("adv5_addr_cur", 32'(addr_cur_ins), 5);

    // Page boundary at ISA_DEPTH*load_times
    jump_to(16'd62);
    check("jmp62", 32'(addr_ins), 62);
    step(); step(); step();
    check("hold_page_64", 32'(addr_ins), 64);
    load_times = 10'd2;
    step();
    check("adv_page2_65", 32'(addr_ins), 65);

    // Upper bound TOTAL_ISA_DEPTH
    load_times = 10'd4;
    jump_to(16'd127);
    step();
    check("adv_to_128", 32'(addr_ins), 128);
    step();
    check("hold_total_128", 32'(addr_ins), 128);

    // Cache not in SENT_INS blocks advance
    jump_to(16'd3);
    st_cur_ins_cache = 4'd0;
    step();
    check("hold_not_sent", 32'(addr_ins), 3);
    st_cur_ins_cache = 4'd3;
    ins_inp_valid = 1'b0;

    // Call / return
    call_valid = 1'b1; call_addr = 16'h0020;
    step();
    call_valid = 1'b0;
    check("call_addr_ins", 32'(addr_ins), 'h20);
    check("call_addr_cur", 32'(addr_cur_ins), 'h20);
    check("call_depth", 32'(stack_depth), 1);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    check("ret_addr_ins", 32'(addr_ins), 4);
    check("ret_addr_cur", 32'(addr_cur_ins), 4);
    check("ret_depth", 32'(stack_depth), 0);

    // Interrupt entry and return
    jump_to(16'd7);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check("int_latency_hold", 32'(addr_ins), 7);
    step();
    check("int_vector", 32'(addr_ins), 'h8000);
    check("int_cur_kept", 32'(addr_cur_ins), 7);
    check("int_in_isr", 32'(in_isr), 1);
    check("int_depth", 32'(stack_depth), 1);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    check("iret_addr", 32'(addr_ins), 7);
    check("iret_in_isr", 32'(in_isr), 0);

    // Interrupt beats ret and adv in the same cycle
    int_req = 1'b1;
    step();
    ret_valid = 1'b1; ins_inp_valid = 1'b1;
    step();
    ret_valid = 1'b0; ins_inp_valid = 1'b0; int_req = 1'b0;
    check("prio_addr", 32'(addr_ins), 'h8000);
    check("prio_depth", 32'(stack_depth), 1);
    check("prio_in_isr", 32'(in_isr), 1);

    // Second interrupt edge while in the ISR
    step();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    step();
`ifdef PC_INT_NEST_EN
    check("nest_depth", 32'(stack_depth), 2);
    check("nest_addr", 32'(addr_ins), 'h8000);
    ret_valid = 1'b1;
    step();
    check("nest_ret1_addr", 32'(addr_ins), 'h8000);
    check("nest_ret1_isr", 32'(in_isr), 1);
    step();
    ret_valid = 1'b0;
    check("nest_ret2_addr", 32'(addr_ins), 7);
    check("nest_ret2_isr", 32'(in_isr), 0);
`else
    check("nonest_depth", 32'(stack_depth), 1);
    step();
    check("nonest_still_held", 32'(stack_depth), 1);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    check("nonest_ret_addr", 32'(addr_ins), 7);
    check("nonest_ret_isr", 32'(in_isr), 0);
    step();
    check("nonest_enter_addr", 32'(addr_ins), 'h8000);
    check("nonest_enter_depth", 32'(stack_depth), 1);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    check("nonest_ret2_addr", 32'(addr_ins), 7);
    check("nonest_ret2_isr", 32'(in_isr), 0);
`endif
    check("after_isr_depth", 32'(stack_depth), 0);

    // Overflow: RET_DEPTH+1 calls from addr 7
    call_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      call_addr = 16'h0100 + 16'(i);
      step();
    end
    check("full_depth", 32'(stack_depth), 8);
    check("full_no_ovf", 32'(stack_ovf), 0);
    call_addr = 16'h0108;
    step();
    call_valid = 1'b0;
    check("ovf_flag", 32'(stack_ovf), 1);
    check("ovf_depth", 32'(stack_depth), 8);
    check("ovf_redirect", 32'(addr_ins), 'h108);

    // Underflow: RET_DEPTH+1 returns
    ret_valid = 1'b1;
    step();
    check("pop_top", 32'(addr_ins), 'h107);
    for (int i = 0; i < 7; i++) step();
    check("pop_bottom", 32'(addr_ins), 8);
    check("pop_depth0", 32'(stack_depth), 0);
    check("pop_no_unf", 32'(stack_unf), 0);
    step();
    ret_valid = 1'b0;
    check("unf_flag", 32'(stack_unf), 1);
    check("unf_hold_addr", 32'(addr_ins), 8);
    check("unf_hold_cur", 32'(addr_cur_ins), 8);
    check("ovf_sticky", 32'(stack_ovf), 1);

    // Reset mid-operation clears flags and a simultaneous pending request
    int_req = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    int_req = 1'b0;
    check("rst2_ovf", 32'(stack_ovf), 0);
    check("rst2_unf", 32'(stack_unf), 0);
    check("rst2_addr", 32'(addr_ins), 0);
    step(); step();
    check("rst2_no_int", 32'(addr_ins), 0);
    check("rst2_depth", 32'(stack_depth), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised instruction-address generator for the associative processor control path. It advances the fetch address under the instruction-cache handshake, and supports call, return and jump. A hardware return-address stack allows nested subroutines and interrupts. Interrupt requests are edge-detected and latched, then redirect fetch to a configurable vector. It sits between AP_ctrl and the instruction cache.

## Interface
- ADDR_WIDTH_MEM, 16, fetch address width
- ISA_DEPTH, 64, instructions per cache load (page size)
- TOTAL_ISA_DEPTH, 128, exclusive upper bound for sequential fetch
- RET_DEPTH, 8, return-stack entries (power of two, ≥2)
- INT_VECTOR, 1<<(ADDR_WIDTH_MEM-1), interrupt entry address
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- int_req  in  1  interrupt request, level; a rising edge is captured
- ret_valid  in  1  return: pop stack into addr_ins
- call_valid  in  1  call: push addr_ins+1, load call_addr
- call_addr  in  ADDR_WIDTH_MEM  call target
- jmp_valid  in  1  jump: load jmp_addr, no push
- jmp_addr  in  ADDR_WIDTH_MEM  jump target
- ins_inp_valid  in  1  AP_ctrl accepts the current instruction
- ins_cache_rdy  in  1  instruction cache ready
- st_cur_ins_cache  in  4  cache state; SENT_INS = 4'd3
- load_times  in  10  completed cache loads
- addr_ins  out  ADDR_WIDTH_MEM  fetch address to the cache
- addr_cur_ins  out  ADDR_WIDTH_MEM  address of the current instruction, to AP_ctrl
- in_isr  out  1  at least one interrupt frame is on the stack
- stack_depth  out  log2(RET_DEPTH)+1  occupied entries
- stack_ovf  out  1  sticky: a push was attempted while the stack was full
- stack_unf  out  1  sticky: a pop was attempted while the stack was empty

## Operation
- Reset values: all outputs 0; stack empty; int_pend 0; int_req edge register 0.
- Interrupt capture: a rising edge of int_req (int_req=1 while its registered copy was 0) sets int_pend.
- Stack entry layout: {is_int, addr}.
- Sequential-advance condition (adv): all of the following hold:
  - ins_inp_valid & ins_cache_rdy
  - st_cur_ins_cache==SENT_INS
  - addr_ins < TOTAL_ISA_DEPTH
  - addr_ins != ISA_DEPTH*load_times, with the product computed at ADDR_WIDTH_MEM+10 bits and addr_ins zero-extended for the compare.
- Per-cycle action, first applicable wins:
  1. Interrupt, when int_pend is set and interrupt entry is allowed: push {1, addr_ins}; addr_ins←INT_VECTOR; clear int_pend.
  2. ret_valid: pop; addr_ins and addr_cur_ins ← popped addr.
  3. call_valid: push {0, addr_ins+1}; addr_ins and addr_cur_ins ← call_addr.
  4. jmp_valid: addr_ins and addr_cur_ins ← jmp_addr.
  5. adv: addr_ins and addr_cur_ins ← addr_ins+1, wrapping modulo 2^ADDR_WIDTH_MEM.
  6. Otherwise: hold.
- Push while full: the entry is dropped, stack_ovf is set, and the redirect still happens.
- Pop while empty: stack_unf is set and addr_ins holds.
- in_isr = OR of is_int over all occupied entries. It clears when the last interrupt frame is popped.
- A lower-priority request that loses in a cycle is dropped. AP_ctrl re-issues it. Exception: int_pend stays latched until serviced.
- A new int_req edge arriving while int_pend is already set merges into the pending request.
- stack_ovf and stack_unf clear only on reset.

## Timing
- Every output is registered; each action is visible on the edge after its request.
- Interrupt latency: edge sampled at edge N → int_pend set at N → addr_ins=INT_VECTOR at N+1 when not blocked.
- Push and pop take one cycle each; stack_depth updates on the same edge as addr_ins.
- Reset asserted mid-operation empties the stack and clears pending requests at the next edge.

## Configuration
- PC_INT_NEST_EN defined: interrupt entry is allowed whenever int_pend is set, including while in_isr=1, so nested frames stack.
- PC_INT_NEST_EN undefined: interrupt entry requires in_isr=0. A pending interrupt waits until the ISR's ret pops its frame, then enters on the following cycle.

## Test plan
- Reset, then 5 cycles of adv with load_times=1 → addr_ins 0→5; hold at 64 because 64==ISA_DEPTH*1; set load_times=2 → advances to 65.
- call_valid, call_addr=0x20 at addr_ins=3 → addr_ins=0x20, stack_depth=1; then ret_valid → addr_ins=4, stack_depth=0.
- int_req pulse at addr_ins=7 → int_pend set, addr_ins=0x8000 one edge later, in_isr=1; ret_valid → addr_ins=7, in_isr=0.
- int_req, ret_valid and adv all asserted in the same cycle with int_pend set → interrupt wins; ret is dropped; stack_depth increments by one.
- RET_DEPTH+1 calls → stack_ovf=1, stack_depth=RET_DEPTH; RET_DEPTH+1 returns → stack_unf=1 and addr_ins holds on the last pop.
- Second int_req edge while in the ISR → with PC_INT_NEST_EN: stack_depth=2 and vector re-entered; without it: held until ret, vector entered on the cycle after ret.
